// File: rtl/usb_fs_tx_serializer.sv
// usb_fs_tx_serializer: UTMI byte stream to full-speed USB D+/D- signalling.
// Define USB_TX_PKT_COUNT_EN to build the sent-packet counter.
module usb_fs_tx_serializer #(
  parameter int CLKS_PER_BIT = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  utmi_tx_data,
  input  logic        utmi_tx_valid,
  output logic        utmi_tx_ready,
  output logic        usb_dp_o,
  output logic        usb_dn_o,
  output logic        usb_oe,
  output logic        tx_busy,
  output logic [15:0] tx_pkt_count
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SYNC = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_SE0  = 3'd3;
  localparam logic [2:0] S_EOPJ = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    sh_q, sh_d;
  logic [2:0]    ones_q, ones_d;
  logic          lvl_q, lvl_d;
  logic          dp_q, dp_d;
  logic          dn_q, dn_d;
  logic          oe_q, oe_d;
  logic          busy_q;
  logic          rdy_q, rdy_d;
  logic          strobe;
  logic          emit;
  logic          emit_bit;
  logic          base;

  assign strobe = (state_q != S_IDLE) && (cnt_q == LAST);

  // ones_q is the run of ones including the bit currently on the line
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    sh_d     = sh_q;
    ones_d   = ones_q;
    rdy_d    = 1'b0;
    emit     = 1'b0;
    emit_bit = 1'b1;
    base     = lvl_q;
    unique case (state_q)
      S_IDLE: begin
        if (utmi_tx_valid) begin
          state_d  = S_SYNC;
          idx_d    = 3'd0;
          emit     = 1'b1;
          emit_bit = 1'b0;
          base     = 1'b1;
        end
      end
      S_SYNC: begin
        if (strobe) begin
          if (idx_q != 3'd7) begin
            idx_d    = idx_q + 3'd1;
            emit     = 1'b1;
            emit_bit = (idx_q == 3'd6);
          end else if (utmi_tx_valid) begin
            state_d  = S_DATA;
            rdy_d    = 1'b1;
            sh_d     = utmi_tx_data;
            idx_d    = 3'd0;
            emit     = 1'b1;
            emit_bit = utmi_tx_data[0];
            ones_d   = utmi_tx_data[0] ? 3'd2 : 3'd0;
          end else begin
            state_d = S_SE0;
            idx_d   = 3'd0;
          end
        end
      end
      S_DATA: begin
        if (strobe) begin
          if (ones_q == 3'd6) begin
            emit     = 1'b1;
            emit_bit = 1'b0;
            ones_d   = 3'd0;
          end else if (idx_q != 3'd7) begin
            sh_d     = sh_q >> 1;
            idx_d    = idx_q + 3'd1;
            emit     = 1'b1;
            emit_bit = sh_q[1];
            ones_d   = sh_q[1] ? ones_q + 3'd1 : 3'd0;
          end else if (utmi_tx_valid) begin
            rdy_d    = 1'b1;
            sh_d     = utmi_tx_data;
            idx_d    = 3'd0;
            emit     = 1'b1;
            emit_bit = utmi_tx_data[0];
            ones_d   = utmi_tx_data[0] ? ones_q + 3'd1 : 3'd0;
          end else begin
            state_d = S_SE0;
            idx_d   = 3'd0;
          end
        end
      end
      S_SE0: begin
        if (strobe) begin
          if (idx_q == 3'd1) state_d = S_EOPJ;
          else idx_d = idx_q + 3'd1;
        end
      end
      S_EOPJ: begin
        if (strobe) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NRZI: a 0 toggles the line, a 1 holds it
  always_comb begin
    lvl_d = lvl_q;
    dp_d  = dp_q;
    dn_d  = dn_q;
    oe_d  = (state_d != S_IDLE);
    if (emit) begin
      lvl_d = emit_bit ? base : ~base;
      dp_d  = lvl_d;
      dn_d  = ~lvl_d;
    end
    if (state_d == S_SE0) begin
      dp_d = 1'b0;
      dn_d = 1'b0;
    end
    if (state_d == S_EOPJ || state_d == S_IDLE) begin
      lvl_d = 1'b1;
      dp_d  = 1'b1;
      dn_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      sh_q    <= 8'd0;
      ones_q  <= 3'd0;
      lvl_q   <= 1'b1;
      dp_q    <= 1'b1;
      dn_q    <= 1'b0;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE || strobe) cnt_q <= '0;
      else cnt_q <= cnt_q + CW'(1);
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      ones_q  <= ones_d;
      lvl_q   <= lvl_d;
      dp_q    <= dp_d;
      dn_q    <= dn_d;
      oe_q    <= oe_d;
      busy_q  <= oe_d;
      rdy_q   <= rdy_d;
    end
  end

  assign utmi_tx_ready = rdy_q;
  assign usb_dp_o      = dp_q;
  assign usb_dn_o      = dn_q;
  assign usb_oe        = oe_q;
  assign tx_busy       = busy_q;

`ifdef USB_TX_PKT_COUNT_EN
  logic        pkt_done;
  logic [15:0] pkt_cnt_q;

  assign pkt_done = (state_q == S_EOPJ) && strobe;

  always_ff @(posedge clk) begin
    if (rst) pkt_cnt_q <= 16'd0;
    else if (pkt_done) pkt_cnt_q <= pkt_cnt_q + 16'd1;
  end

  assign tx_pkt_count = pkt_cnt_q;
`else
  assign tx_pkt_count = 16'd0;
`endif

endmodule
